// File: rtl/stl_pkg.sv
// Shared types and constants for the stl pipeline-register family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stl_pkg;

    // Skid buffer has a main slot and a single overflow slot.
    localparam int SKID_DEPTH = 2;

    // Encoding is chosen so the state value is directly the occupancy count.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } stl_skid_state_e;

endpackage

// File: rtl/stl_reg.sv
// Enable register with asynchronous active-low reset to a parameterised value.
// Latency: 1 cycle from i_d/i_wen to o_q.
// Backpressure: none; holds its value whenever i_wen is low.
// Ports: i_clk clock, i_rst_n async reset, i_wen write enable, i_d next value, o_q stored value.
module stl_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= RESET_VAL;
        end else if (i_wen) begin
            data_q <= i_d;
        end
    end

    assign o_q = data_q;

endmodule

// File: rtl/stl_skid_buf.sv
// Two-entry valid/ready skid buffer decoupling a producer stage from a consumer stage.
// Latency: 1 cycle (beat accepted at edge N is visible on o_data/o_valid after edge N).
// Backpressure: o_ready is decoded from registered occupancy only; one extra beat is absorbed in SKID.
// Ports: i_clk/i_rst_n clock and async reset, i_flush sync discard,
//        i_valid/o_ready/i_data upstream handshake, o_valid/i_ready/o_data downstream handshake,
//        o_count current occupancy (0..2).
module stl_skid_buf
    import stl_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [$clog2(SKID_DEPTH+1)-1:0] o_count
);

    logic [1:0]       state_raw_q;
    stl_skid_state_e  state_q;
    stl_skid_state_e  state_d;
    logic             state_wen;

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic             main_wen;
    logic [WIDTH-1:0] skid_q;
    logic             skid_wen;

    logic             in_fire;
    logic             out_fire;

    assign state_q = stl_skid_state_e'(state_raw_q);

    // Handshake outputs come only from registered state, which keeps
    // i_valid/i_ready off any combinational path to the opposite side.
    assign o_valid = (state_q != SKID_EMPTY);
    assign o_ready = (state_q != SKID_FULL);
    assign o_count = state_raw_q;
    assign o_data  = main_q;

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_comb begin
        state_d  = state_q;
        main_d   = i_data;
        main_wen = 1'b0;
        skid_wen = 1'b0;

        if (i_flush) begin
            // Slots are left untouched so o_data keeps its last value.
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        state_d  = SKID_ONE;
                        main_wen = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (in_fire && !out_fire) begin
                        // Consumer stalled while a new beat arrived: park it.
                        state_d  = SKID_FULL;
                        skid_wen = 1'b1;
                    end else if (!in_fire && out_fire) begin
                        state_d = SKID_EMPTY;
                    end else if (in_fire && out_fire) begin
                        main_wen = 1'b1;
                    end
                end
                SKID_FULL: begin
                    // o_ready is low here, so only the drain path exists.
                    if (out_fire) begin
                        state_d  = SKID_ONE;
                        main_d   = skid_q;
                        main_wen = 1'b1;
                    end
                end
                default: begin
                    state_d = SKID_EMPTY;
                end
            endcase
        end

        state_wen = (state_d != state_q);
    end

    stl_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wen   (main_wen),
        .i_d     (main_d),
        .o_q     (main_q)
    );

    stl_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wen   (skid_wen),
        .i_d     (i_data),
        .o_q     (skid_q)
    );

    stl_reg #(
        .WIDTH     (2),
        .RESET_VAL (2'(SKID_EMPTY))
    ) u_state_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wen   (state_wen),
        .i_d     (2'(state_d)),
        .o_q     (state_raw_q)
    );

endmodule

// File: tb/tb_stl_skid_buf.sv
module tb_stl_skid_buf;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [1:0]  o_count;

    int errors = 0;
    int checks = 0;

    // Reference model: the held beats in arrival order, plus the value that
    // was most recently at the head (what the output register still shows).
    logic [31:0] q[$];
    logic [31:0] last_head = 32'h0;

    always #5 i_clk = ~i_clk;

    stl_skid_buf #(
        .WIDTH     (32),
        .RESET_VAL (32'h0)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'(q.size() > 0));
        chk({tag, "_ready"}, 32'(o_ready), 32'(q.size() < 2));
        chk({tag, "_count"}, 32'(o_count), 32'(q.size()));
        chk({tag, "_data"},  o_data, last_head);
    endtask

    // Called at a negedge: check current outputs, drive one cycle, advance
    // the model across the rising edge, return at the next negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        bit in_f;
        bit out_f;
        chk_model("step");
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        in_f  = v && (q.size() < 2);
        out_f = r && (q.size() > 0);
        @(posedge i_clk);
        if (f) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f)  q.push_back(d);
        end
        if (q.size() > 0) last_head = q[0];
        @(negedge i_clk);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hAAAA_AAAA;
        i_ready = 1'b0;

        // Reset with traffic presented: nothing may be captured.
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("rst_valid", 32'(o_valid), 32'd0);
            chk("rst_ready", 32'(o_ready), 32'd1);
            chk("rst_count", 32'(o_count), 32'd0);
            chk("rst_data",  o_data, 32'h0);
        end
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_rst_valid", 32'(o_valid), 32'd0);
        chk("post_rst_data",  o_data, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Streaming with the consumer always ready.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'(i), 1'b1, 1'b0);
            chk("stream_data", o_data, 32'(i));
            chk("stream_cnt_le1", 32'(o_count <= 2'd1), 32'd1);
            chk("stream_ready", 32'(o_ready), 32'd1);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: one extra beat lands in SKID, third is held upstream.
        step(1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b1, 32'h11, 1'b0, 1'b0);
        chk("bp_count", 32'(o_count), 32'd2);
        chk("bp_ready", 32'(o_ready), 32'd0);
        chk("bp_data",  o_data, 32'h10);
        step(1'b1, 32'h12, 1'b0, 1'b0);
        chk("bp_hold_count", 32'(o_count), 32'd2);
        step(1'b1, 32'h12, 1'b1, 1'b0);
        chk("bp_drain1", o_data, 32'h11);
        chk("bp_recover_ready", 32'(o_ready), 32'd1);
        step(1'b1, 32'h12, 1'b1, 1'b0);
        chk("bp_drain2", o_data, 32'h12);
        chk("bp_drain2_valid", 32'(o_valid), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous in/out fire while holding one beat.
        step(1'b1, 32'h20, 1'b0, 1'b0);
        step(1'b1, 32'h21, 1'b1, 1'b0);
        chk("sim_data",  o_data, 32'h21);
        chk("sim_count", 32'(o_count), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush wins over both handshakes while FULL.
        step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b1, 32'h41, 1'b0, 1'b0);
        step(1'b1, 32'h30, 1'b1, 1'b1);
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_count", 32'(o_count), 32'd0);
        chk("flush_ready", 32'(o_ready), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_0x30", 32'(o_valid), 32'd0);

        // Asynchronous reset while FULL, asserted between edges.
        step(1'b1, 32'h50, 1'b0, 1'b0);
        step(1'b1, 32'h51, 1'b0, 1'b0);
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_ready", 32'(o_ready), 32'd1);
        chk("arst_data",  o_data, 32'h0);
        q.delete();
        last_head = 32'h0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Randomised traffic against the queue model.
        for (int n = 0; n < 2000; n++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        chk_model("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
